mwb_stage: RTL and testbench

Third stage (memory/writeback) of the three-stage RV32I pipeline, directly downstream of the execute stage.
- Registers the execute-stage results each cycle.
- Extracts and sign/zero-extends load data from the synchronous-read DMEM or the IO space.
- Selects the register-file write data and generates the write enable.
- Exports a forwarding tap back to execute.
- Maintains cycle and retired-instruction counters for the IO counter registers.

---
 rtl/rv32_pkg.sv | 27 ++
 rtl/mwb_stage_if.sv | 39 +++
 rtl/load_extract.sv | 36 +++
 rtl/mwb_stage.sv | 102 ++++++++++
 tb/tb_mwb_stage.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the pipeline: opcodes, load funct3 codes,
// the bubble instruction and the performance counter width.
package rv32_pkg;

   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   // addi x0,x0,0: the bubble injected on reset and flush
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int CNT_W = 32;

endpackage

// File: rtl/mwb_stage_if.sv
// Signal bundle between the execute side / memories and the MWB stage.
// There is no valid/ready handshake: every input is sampled each cycle,
// stall holds the stage registers and flush replaces the incoming
// instruction with a bubble (flush has priority over stall).
interface mwb_stage_if #(
   parameter int CNT_W = rv32_pkg::CNT_W
);
   logic             stall;
   logic             flush;
   logic [31:0]      instruction_EXE;
   logic [31:0]      PC;
   logic [31:0]      ALU_result;
   logic [31:0]      DMEM_data_out;
   logic [31:0]      IO_data_out;
   logic             cnt_clr;
   logic [31:0]      instruction_MWB;
   logic [31:0]      DataDin;
   logic             Reg_WE;
   logic [4:0]       fwd_rd;
   logic             fwd_valid;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instret_cnt;

   // driven by execute / memories / counter control
   modport master (
      output stall, flush, instruction_EXE, PC, ALU_result,
             DMEM_data_out, IO_data_out, cnt_clr,
      input  instruction_MWB, DataDin, Reg_WE, fwd_rd, fwd_valid,
             cycle_cnt, instret_cnt
   );

   // the MWB stage itself
   modport slave (
      input  stall, flush, instruction_EXE, PC, ALU_result,
             DMEM_data_out, IO_data_out, cnt_clr,
      output instruction_MWB, DataDin, Reg_WE, fwd_rd, fwd_valid,
             cycle_cnt, instret_cnt
   );
endinterface

// File: rtl/load_extract.sv
// Load data alignment: picks the byte/half/word addressed by addr_i out of
// the read word and sign- or zero-extends it according to funct3.
module load_extract
   import rv32_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // lane select then extension; addr_i[0] is ignored for halves
   always_comb begin
      byte_sel = word_i[7:0];
      case (addr_i)
         2'd1:    byte_sel = word_i[15:8];
         2'd2:    byte_sel = word_i[23:16];
         2'd3:    byte_sel = word_i[31:24];
         default: byte_sel = word_i[7:0];
      endcase
      half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
      data_o   = '0;
      case (funct3_i)
         F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  data_o = {24'd0, byte_sel};
         F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  data_o = {16'd0, half_sel};
         F3_LW:   data_o = word_i;
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/mwb_stage.sv
// Memory/writeback stage: registers the execute results, extracts load
// data, selects register-file write data and enable, exports the
// forwarding tap and keeps the cycle / retired-instruction counters.
module mwb_stage
   import rv32_pkg::*;
#(
   parameter logic [31:0] NOP_VAL   = NOP_INSTR,
   parameter logic [3:0]  IO_NIBBLE = 4'h8,
   parameter int          CW        = CNT_W
) (
   input  logic        clk,
   input  logic        rst,
   mwb_stage_if.slave  bus
);

   logic [31:0]   instr_q, instr_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   alu_q, alu_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic [CW-1:0] ret_q, ret_d;

   logic [31:0] src_word;
   logic [31:0] load_data;
   logic [31:0] wb_data;
   logic        wb_class;
   logic [4:0]  rd;

   // pipeline register next state: flush beats stall, stall holds
   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      alu_d   = alu_q;
      if (bus.flush) begin
         instr_d = NOP_VAL;
         pc_d    = bus.PC;
         alu_d   = bus.ALU_result;
      end else if (!bus.stall) begin
         instr_d = bus.instruction_EXE;
         pc_d    = bus.PC;
         alu_d   = bus.ALU_result;
      end
   end

   // counters: a stalled instruction retires only on the cycle it leaves
   always_comb begin
      cyc_d = cyc_q + CW'(1);
      ret_d = ret_q;
      if (instr_q != NOP_VAL && !bus.stall) ret_d = ret_q + CW'(1);
      if (bus.cnt_clr) begin
         cyc_d = '0;
         ret_d = '0;
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q <= NOP_VAL;
         pc_q    <= '0;
         alu_q   <= '0;
         cyc_q   <= '0;
         ret_q   <= '0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         alu_q   <= alu_d;
         cyc_q   <= cyc_d;
         ret_q   <= ret_d;
      end
   end

   assign src_word = (alu_q[31:28] == IO_NIBBLE) ? bus.IO_data_out : bus.DMEM_data_out;

   load_extract u_load_extract (
      .word_i   (src_word),
      .funct3_i (instr_q[14:12]),
      .addr_i   (alu_q[1:0]),
      .data_o   (load_data)
   );

   // writeback mux; store/branch/system/unknown pass alu_q with no write
   always_comb begin
      wb_data  = alu_q;
      wb_class = 1'b0;
      case (instr_q[6:0])
         LOAD:                    begin wb_data = load_data;      wb_class = 1'b1; end
         JAL, JALR:               begin wb_data = pc_q + 32'd4;   wb_class = 1'b1; end
         LUI, AUIPC, OP, OP_IMM:  begin wb_data = alu_q;          wb_class = 1'b1; end
         default:                 begin wb_data = alu_q;          wb_class = 1'b0; end
      endcase
   end

   assign rd                  = instr_q[11:7];
   assign bus.instruction_MWB = instr_q;
   assign bus.DataDin         = wb_data;
   assign bus.Reg_WE          = wb_class && (rd != 5'd0);
   assign bus.fwd_rd          = rd;
   assign bus.fwd_valid       = bus.Reg_WE;
   assign bus.cycle_cnt       = cyc_q;
   assign bus.instret_cnt     = ret_q;

endmodule

// File: tb/tb_mwb_stage.sv
// Self-checking bench for mwb_stage: directed scenarios plus a randomized
// run, all checked against a spec-level reference model kept here.
module tb_mwb_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   mwb_stage_if bus ();

   mwb_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic [31:0] m_instr, m_pc, m_alu;
   logic [31:0] m_cyc, m_ret;
   logic [31:0] m_dm, m_io;

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off);
      logic signed [31:0] s;
      int bsh, hsh;
      bsh = 8 * int'(off);
      hsh = 16 * int'(off[1]);
      case (f3)
         3'd0: begin s = w << (24 - bsh); return s >>> 24; end
         3'd4: return (w >> bsh) & 32'h0000_00FF;
         3'd1: begin s = w << (16 - hsh); return s >>> 16; end
         3'd5: return (w >> hsh) & 32'h0000_FFFF;
         3'd2: return w;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_we(input logic [31:0] ins);
      logic wr;
      case (ins[6:0])
         7'h03, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33, 7'h13: wr = 1'b1;
         default: wr = 1'b0;
      endcase
      return wr && (ins[11:7] != 5'd0);
   endfunction

   function automatic logic [31:0] ref_data(input logic [31:0] ins, input logic [31:0] pc,
                                            input logic [31:0] alu, input logic [31:0] dm,
                                            input logic [31:0] io);
      logic [31:0] w;
      w = (alu[31:28] == 4'h8) ? io : dm;
      case (ins[6:0])
         7'h03:        return ref_load(w, ins[14:12], alu[1:0]);
         7'h6F, 7'h67: return pc + 32'd4;
         default:      return alu;
      endcase
   endfunction

   // driver: present EX inputs, clock once, update model, then return the
   // memory read data for the instruction now in MWB
   task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
                       input logic st, input logic fl, input logic cl,
                       input logic [31:0] dm, input logic [31:0] io);
      bus.instruction_EXE = ins;
      bus.PC              = pc;
      bus.ALU_result      = alu;
      bus.stall           = st;
      bus.flush           = fl;
      bus.cnt_clr         = cl;
      @(posedge clk);
      if (rst) begin
         m_cyc = 0; m_ret = 0;
      end else if (cl) begin
         m_cyc = 0; m_ret = 0;
      end else begin
         m_cyc = m_cyc + 1;
         if (m_instr != NOP && !st) m_ret = m_ret + 1;
      end
      if (rst) begin
         m_instr = NOP; m_pc = 0; m_alu = 0;
      end else if (fl) begin
         m_instr = NOP; m_pc = pc; m_alu = alu;
      end else if (!st) begin
         m_instr = ins; m_pc = pc; m_alu = alu;
      end
      #1;
      bus.DMEM_data_out = dm;
      bus.IO_data_out   = io;
      m_dm = dm;
      m_io = io;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(32'h0000_0283, 32'h40, 32'h1234, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
      step(32'h0000_0283, 32'h44, 32'h1234, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
      checks++;
      if (bus.instruction_MWB !== NOP) begin
         errors++; $display("FAIL reset_instr: got %h expected %h", bus.instruction_MWB, NOP);
      end
      checks++;
      if (bus.Reg_WE !== 1'b0) begin
         errors++; $display("FAIL reset_we: got %b expected 0", bus.Reg_WE);
      end
      checks++;
      if (bus.DataDin !== 32'd0) begin
         errors++; $display("FAIL reset_data: got %h expected 0", bus.DataDin);
      end
      checks++;
      if (bus.cycle_cnt !== 32'd0 || bus.instret_cnt !== 32'd0) begin
         errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", bus.cycle_cnt, bus.instret_cnt);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(NOP, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         checks++;
         if (bus.cycle_cnt !== 32'(i + 1) || bus.instret_cnt !== 32'd0) begin
            errors++;
            $display("FAIL release_cnt%0d: got %0d/%0d expected %0d/0", i,
                     bus.cycle_cnt, bus.instret_cnt, i + 1);
         end
      end
   endtask

   task automatic test_loads();
      logic [31:0] ins [3] = '{32'h0000_0283, 32'h0000_4283, 32'h0000_5283};
      logic [31:0] adr [3] = '{32'h0000_1003, 32'h0000_1003, 32'h0000_1002};
      logic [31:0] exp [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
      for (int i = 0; i < 3; i++) begin
         step(ins[i], 32'h100, adr[i], 1'b0, 1'b0, 1'b0, 32'h80FF_7F01, 32'h0);
         checks++;
         if (bus.DataDin !== exp[i]) begin
            errors++; $display("FAIL load%0d_data: got %h expected %h", i, bus.DataDin, exp[i]);
         end
         checks++;
         if (bus.Reg_WE !== 1'b1 || bus.fwd_rd !== 5'd5 || bus.fwd_valid !== 1'b1) begin
            errors++;
            $display("FAIL load%0d_we: got we=%b rd=%0d fv=%b expected 1/5/1", i,
                     bus.Reg_WE, bus.fwd_rd, bus.fwd_valid);
         end
      end
   endtask

   task automatic test_jal_wrap();
      step(32'h0000_00EF, 32'hFFFF_FFFC, 32'h0000_0444, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (bus.DataDin !== 32'd0 || bus.Reg_WE !== 1'b1) begin
         errors++; $display("FAIL jal_wrap: got %h we=%b expected 00000000 we=1", bus.DataDin, bus.Reg_WE);
      end
      step(32'h0000_006F, 32'hFFFF_FFFC, 32'h0000_0444, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (bus.Reg_WE !== 1'b0 || bus.fwd_valid !== 1'b0) begin
         errors++; $display("FAIL jal_x0_we: got %b/%b expected 0/0", bus.Reg_WE, bus.fwd_valid);
      end
   endtask

   task automatic test_io_load();
      step(32'h0000_2283, 32'h200, 32'h8000_0010, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
      checks++;
      if (bus.DataDin !== 32'h1234_5678) begin
         errors++; $display("FAIL io_load: got %h expected 12345678", bus.DataDin);
      end
   endtask

   task automatic test_stall();
      logic [31:0] held;
      logic [31:0] r0;
      held = m_instr;
      for (int i = 0; i < 3; i++) begin
         step(32'h0000_0193, 32'h300, 32'h7, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
         checks++;
         if (bus.instruction_MWB !== held) begin
            errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, bus.instruction_MWB, held);
         end
      end
      step(32'h0000_0193, 32'h300, 32'h7, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (bus.instruction_MWB !== 32'h0000_0193 || bus.DataDin !== 32'h7 || bus.fwd_rd !== 5'd3) begin
         errors++; $display("FAIL stall_release: got %h data=%h expected 00000193 data=7",
                            bus.instruction_MWB, bus.DataDin);
      end
      r0 = m_ret;
      for (int i = 0; i < 3; i++) begin
         step(NOP, 32'h304, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
         checks++;
         if (bus.instret_cnt !== r0) begin
            errors++; $display("FAIL stall_instret%0d: got %0d expected %0d", i, bus.instret_cnt, r0);
         end
      end
      step(NOP, 32'h304, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(NOP, 32'h308, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (bus.instret_cnt !== r0 + 32'd1) begin
         errors++; $display("FAIL stall_retire_once: got %0d expected %0d", bus.instret_cnt, r0 + 1);
      end
   endtask

   task automatic test_flush_clr();
      step(32'h0000_00EF, 32'h400, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(32'h0050_2023, 32'h404, 32'h1000, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      checks++;
      if (bus.instruction_MWB !== NOP || bus.Reg_WE !== 1'b0) begin
         errors++; $display("FAIL flush_stall: got %h we=%b expected %h we=0",
                            bus.instruction_MWB, bus.Reg_WE, NOP);
      end
      step(32'h0000_0193, 32'h408, 32'h5, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      checks++;
      if (bus.cycle_cnt !== 32'd0 || bus.instret_cnt !== 32'd0) begin
         errors++; $display("FAIL cnt_clr: got %0d/%0d expected 0/0", bus.cycle_cnt, bus.instret_cnt);
      end
      step(NOP, 32'h40C, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (bus.cycle_cnt !== 32'd1 || bus.instret_cnt !== 32'd1) begin
         errors++; $display("FAIL cnt_after_clr: got %0d/%0d expected 1/1", bus.cycle_cnt, bus.instret_cnt);
      end
   endtask

   task automatic test_random();
      logic [6:0]  ops [11] = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37,
                               7'h17, 7'h33, 7'h13, 7'h73, 7'h7F};
      logic [31:0] ins, alu;
      for (int n = 0; n < 300; n++) begin
         ins = {$urandom(), 7'h00} | 32'(ops[$urandom_range(0, 10)]);
         if ($urandom_range(0, 7) == 0) ins = NOP;
         if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
         alu = $urandom();
         if ($urandom_range(0, 3) == 0) alu[31:28] = 4'h8;
         step(ins, $urandom(), alu, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 19) == 0), $urandom(), $urandom());
         checks++;
         if (bus.instruction_MWB !== m_instr) begin
            errors++; $display("FAIL rnd_instr@%0d: got %h expected %h", n, bus.instruction_MWB, m_instr);
         end
         checks++;
         if (bus.DataDin !== ref_data(m_instr, m_pc, m_alu, m_dm, m_io)) begin
            errors++; $display("FAIL rnd_data@%0d: got %h expected %h", n, bus.DataDin,
                               ref_data(m_instr, m_pc, m_alu, m_dm, m_io));
         end
         checks++;
         if (bus.Reg_WE !== ref_we(m_instr) || bus.fwd_valid !== ref_we(m_instr)) begin
            errors++; $display("FAIL rnd_we@%0d: got %b/%b expected %b", n, bus.Reg_WE,
                               bus.fwd_valid, ref_we(m_instr));
         end
         checks++;
         if (bus.fwd_rd !== m_instr[11:7]) begin
            errors++; $display("FAIL rnd_rd@%0d: got %0d expected %0d", n, bus.fwd_rd, m_instr[11:7]);
         end
         checks++;
         if (bus.cycle_cnt !== m_cyc || bus.instret_cnt !== m_ret) begin
            errors++; $display("FAIL rnd_cnt@%0d: got %0d/%0d expected %0d/%0d", n,
                               bus.cycle_cnt, bus.instret_cnt, m_cyc, m_ret);
         end
      end
   endtask

   // test sequence and final report
   initial begin
      rst = 1'b1;
      m_instr = NOP; m_pc = 0; m_alu = 0; m_cyc = 0; m_ret = 0; m_dm = 0; m_io = 0;
      bus.stall = 1'b0; bus.flush = 1'b0; bus.cnt_clr = 1'b0;
      bus.instruction_EXE = NOP; bus.PC = '0; bus.ALU_result = '0;
      bus.DMEM_data_out = '0; bus.IO_data_out = '0;
      test_reset();
      test_loads();
      test_jal_wrap();
      test_io_load();
      test_stall();
      test_flush_clr();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
